// File: rtl/memory_data_port_arbiter_pkg.sv
// Shared definitions for the main-memory data-port arbiter.
// Contents:
//   - AddrWDefault / DataWDefault : default address and word widths of the 32x20 memory
//   - arb_state_e                 : arbiter FSM state encoding
//   - owner_e                     : which requester currently drives the data port
//   - state_owner()               : maps an FSM state onto the port owner
package memory_data_port_arbiter_pkg;

  localparam int unsigned AddrWDefault = 5;
  localparam int unsigned DataWDefault = 20;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StServeP = 3'd1,
    StServeL = 3'd2,
    StAckP   = 3'd3,
    StAckL   = 3'd4
  } arb_state_e;

  // Owner-select codes; also consumed by the pipeline hazard unit.
  typedef enum logic [1:0] {
    OwnerNone = 2'd0,
    OwnerP    = 2'd1,
    OwnerL    = 2'd2
  } owner_e;

  // Only the SERVE states drive the memory port.
  function automatic owner_e state_owner(arb_state_e s);
    owner_e o;
    case (s)
      StServeP: o = OwnerP;
      StServeL: o = OwnerL;
      default:  o = OwnerNone;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/memory_data_port_arbiter.sv
// Arbitrates the single data-side port of the main memory between the pipeline
// MEM stage (P) and the program/debug loader (L).
// Each access runs SERVE (port granted, write strobed, read captured at the
// closing edge) then ACK (one-cycle completion pulse). P wins collisions out of
// IDLE; after every ACK the other requester is served first if it is waiting.
// Ports:
//   Clock, Reset                         : clock, asynchronous active-high reset
//   p_req/p_we/p_addr/p_wdata            : pipeline request and operands
//   p_gnt/p_ack/p_rdata/p_stall          : pipeline grant, completion, read data, stall
//   l_req/l_we/l_addr/l_wdata            : loader request and operands
//   l_gnt/l_ack/l_rdata                  : loader grant, completion, read data
//   mem_addr/data/wr_en                  : to memory data port (memory writes on negedge)
//   q_mem                                : combinational read data from memory
module memory_data_port_arbiter
  import memory_data_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDefault,
  parameter int unsigned DATA_W = DataWDefault
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              p_req,
  input  logic              p_we,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic              p_gnt,
  output logic              p_ack,
  output logic [DATA_W-1:0] p_rdata,
  output logic              p_stall,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_ack,
  output logic [DATA_W-1:0] l_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] data,
  output logic              wr_en,
  input  logic [DATA_W-1:0] q_mem
);

  arb_state_e        state_q, state_d;
  logic [DATA_W-1:0] p_rdata_q, p_rdata_d;
  logic [DATA_W-1:0] l_rdata_q, l_rdata_d;

  // Next-state and read-data capture. A requester whose req has dropped by the
  // end of its SERVE cycle is treated as aborted: no capture, no ACK.
  always_comb begin
    state_d   = state_q;
    p_rdata_d = p_rdata_q;
    l_rdata_d = l_rdata_q;
    case (state_q)
      StIdle: begin
        if (p_req) begin
          state_d = StServeP;
        end else if (l_req) begin
          state_d = StServeL;
        end
      end
      StServeP: begin
        if (p_req) begin
          state_d = StAckP;
          if (!p_we) p_rdata_d = q_mem;
        end else begin
          state_d = StIdle;
        end
      end
      StServeL: begin
        if (l_req) begin
          state_d = StAckL;
          if (!l_we) l_rdata_d = q_mem;
        end else begin
          state_d = StIdle;
        end
      end
      // The acked requester's own req is ignored here so it can drop req
      // one edge later without being regranted.
      StAckP:  state_d = l_req ? StServeL : StIdle;
      StAckL:  state_d = p_req ? StServeP : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= StIdle;
      p_rdata_q <= '0;
      l_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      p_rdata_q <= p_rdata_d;
      l_rdata_q <= l_rdata_d;
    end
  end

  // Port mux and handshake outputs, all decoded from the registered state.
  // Reset forces IDLE asynchronously, so wr_en drops before the memory's negedge.
  always_comb begin
    p_gnt    = (state_q == StServeP);
    l_gnt    = (state_q == StServeL);
    p_ack    = (state_q == StAckP);
    l_ack    = (state_q == StAckL);
    p_rdata  = p_rdata_q;
    l_rdata  = l_rdata_q;
    mem_addr = '0;
    data     = '0;
    wr_en    = 1'b0;
    case (state_owner(state_q))
      OwnerP: begin
        mem_addr = p_addr;
        data     = p_wdata;
        wr_en    = p_we & p_req;
      end
      OwnerL: begin
        mem_addr = l_addr;
        data     = l_wdata;
        wr_en    = l_we & l_req;
      end
      default: ;
    endcase
    p_stall = p_req & ~p_ack;
  end

endmodule
